// File: rtl/mdu_sequencer.sv
// Iterative RV32IM M-extension unit: shift-add multiplier and restoring divider
// sharing one accumulator, sequenced beside the ALU in EX.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for START with an M-op opcode
// S_MUL_RUN | 32 shift-add steps, BUSY high
// S_DIV_RUN | 32 restoring-division steps, BUSY high
// S_DONE    | one-cycle DONE pulse, RESULT valid; may accept a new START
module mdu_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [4:0]      OPCODE,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   localparam logic [4:0] OP_MUL    = 5'b01010;
   localparam logic [4:0] OP_MULH   = 5'b01011;
   localparam logic [4:0] OP_MULHU  = 5'b01100;
   localparam logic [4:0] OP_MULHSU = 5'b01101;
   localparam logic [4:0] OP_DIV    = 5'b01110;
   localparam logic [4:0] OP_DIVU   = 5'b01111;
   localparam logic [4:0] OP_REM    = 5'b10000;
   localparam logic [4:0] OP_REMU   = 5'b10001;

   typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [4:0]          op_q;
   logic [XLEN-1:0]     opnd_q;
   logic [2*XLEN-1:0]   acc_q;
   logic                neg_q;
   logic                busy_q, done_q, busy_d, done_d;
   logic [XLEN-1:0]     result_q;

   logic                is_mul, is_div, is_mop, accept, fast, last;
   logic                sign1, sign2, neg_d, div_by_zero, overflow;
   logic [XLEN-1:0]     mag_a, mag_b, fast_result, fin_result;
   logic [XLEN:0]       mul_sum, rem_sh;
   logic                rem_ge;
   logic [XLEN-1:0]     rem_sub;
   logic [2*XLEN-1:0]   acc_step, prod;
   logic [XLEN-1:0]     quo_s, rem_s;

   // Request decode and operand conditioning at accept.
   always_comb begin
      is_mul = (OPCODE == OP_MUL) || (OPCODE == OP_MULH) ||
               (OPCODE == OP_MULHU) || (OPCODE == OP_MULHSU);
      is_div = (OPCODE == OP_DIV) || (OPCODE == OP_DIVU) ||
               (OPCODE == OP_REM) || (OPCODE == OP_REMU);
      is_mop = is_mul || is_div;
      accept = START && !FLUSH && is_mop &&
               ((state_q == S_IDLE) || (state_q == S_DONE));
      sign1  = DATA1[XLEN-1] && ((OPCODE == OP_MULH) || (OPCODE == OP_MULHSU) ||
                                 (OPCODE == OP_DIV) || (OPCODE == OP_REM));
      sign2  = DATA2[XLEN-1] && ((OPCODE == OP_MULH) || (OPCODE == OP_DIV) ||
                                 (OPCODE == OP_REM));
      mag_a  = sign1 ? -DATA1 : DATA1;
      mag_b  = sign2 ? -DATA2 : DATA2;
      neg_d  = (OPCODE == OP_REM) ? sign1 : (sign1 ^ sign2);
      div_by_zero = is_div && (DATA2 == '0);
      overflow    = ((OPCODE == OP_DIV) || (OPCODE == OP_REM)) &&
                    (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
      fast        = div_by_zero || overflow;
      if (div_by_zero)
         fast_result = ((OPCODE == OP_DIV) || (OPCODE == OP_DIVU)) ? '1 : DATA1;
      else
         fast_result = (OPCODE == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
   end

   // One iteration step: acc = {high/remainder, low/multiplier-or-quotient}.
   always_comb begin
      last    = (cnt_q == CNT_W'(XLEN-1));
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      rem_ge  = (rem_sh >= {1'b0, opnd_q});
      rem_sub = rem_sh[XLEN-1:0] - opnd_q;
      if (state_q == S_MUL_RUN)
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      else if (rem_ge)
         acc_step = {rem_sub, acc_q[XLEN-2:0], 1'b1};
      else
         acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   always_comb begin
      prod  = neg_q ? -acc_step : acc_step;
      quo_s = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_s = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                         fin_result = prod[XLEN-1:0];
         OP_MULH, OP_MULHU, OP_MULHSU:   fin_result = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:                fin_result = quo_s;
         OP_REM, OP_REMU:                fin_result = rem_s;
         default:                        fin_result = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // FLUSH outranks START everywhere.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (FLUSH)       state_d = S_IDLE;
            else if (accept) state_d = fast ? S_DONE : (is_mul ? S_MUL_RUN : S_DIV_RUN);
            else             state_d = S_IDLE;
         end
         S_MUL_RUN, S_DIV_RUN: begin
            if (FLUSH)     state_d = S_IDLE;
            else if (last) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d = (state_d == S_MUL_RUN) || (state_d == S_DIV_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
         op_q  <= OPCODE;
         neg_q <= neg_d;
         if (is_mul) begin
            opnd_q <= mag_a;
            acc_q  <= {{XLEN{1'b0}}, mag_b};
         end else begin
            opnd_q <= mag_b;
            acc_q  <= {{XLEN{1'b0}}, mag_a};
         end
         if (fast)
            result_q <= fast_result;
      end else if ((state_q == S_MUL_RUN) || (state_q == S_DIV_RUN)) begin
         if (FLUSH) begin
            cnt_q <= '0;
         end else begin
            acc_q <= acc_step;
            cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
            if (last)
               result_q <= fin_result;
         end
      end
   end

   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, results, fast paths, FLUSH,
// asynchronous reset and ignored requests.
module tb_mdu_sequencer;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START;
   logic [4:0]  OPCODE;
   logic [31:0] DATA1, DATA2;
   logic        FLUSH;
   logic        BUSY, DONE;
   logic [31:0] RESULT;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [4:0] OP_MUL    = 5'b01010;
   localparam logic [4:0] OP_MULH   = 5'b01011;
   localparam logic [4:0] OP_MULHU  = 5'b01100;
   localparam logic [4:0] OP_MULHSU = 5'b01101;
   localparam logic [4:0] OP_DIV    = 5'b01110;
   localparam logic [4:0] OP_DIVU   = 5'b01111;
   localparam logic [4:0] OP_REM    = 5'b10000;
   localparam logic [4:0] OP_REMU   = 5'b10001;

   mdu_sequencer #(.XLEN(32), .CNT_W(6)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE),
      .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Issues one request and stops in the cycle DONE is seen (lat = -1 on timeout).
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int lat, output logic [31:0] res);
      bit got;
      OPCODE = op; DATA1 = a; DATA2 = b; START = 1'b1;
      tick();
      START = 1'b0;
      nbusy = 0; lat = -1; res = 'x; got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         if (BUSY) nbusy++;
         if (DONE) begin
            lat = i; res = RESULT; got = 1'b1;
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
      vectors++;
      if (DONE !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", DONE); end
      vectors++;
      if (RESULT !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 00000000", RESULT); end
      @(negedge CLK);
      RESET = 1'b1;
      tick();
   endtask

   task automatic test_mul();
      int nb, lat; logic [31:0] r;
      issue(OP_MUL, 32'h00000007, 32'hFFFFFFFD, nb, lat, r);
      vectors++;
      if (nb !== 32) begin miscompares++; $display("FAIL mul_busy_cycles: got %0d expected 32", nb); end
      vectors++;
      if (lat !== 33) begin miscompares++; $display("FAIL mul_latency: got %0d expected 33", lat); end
      vectors++;
      if (r !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mul_result: got %h expected FFFFFFEB", r); end
      tick();
      vectors++;
      if (DONE !== 1'b0) begin miscompares++; $display("FAIL mul_done_width: got %b expected 0", DONE); end
   endtask

   task automatic test_mulh_back_to_back();
      logic [4:0]  ops [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
      logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] ex  [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
      int nb, lat; logic [31:0] r;
      for (int k = 0; k < 3; k++) begin
         issue(ops[k], as[k], bs[k], nb, lat, r);
         vectors++;
         if (lat !== 33) begin miscompares++; $display("FAIL mulh%0d_latency: got %0d expected 33", k, lat); end
         vectors++;
         if (r !== ex[k]) begin miscompares++; $display("FAIL mulh%0d_result: got %h expected %h", k, r, ex[k]); end
      end
      tick();
   endtask

   task automatic test_div();
      logic [4:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
      logic [31:0] ex  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
      int nb, lat; logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         issue(ops[k], 32'hFFFFFFF9, 32'h00000002, nb, lat, r);
         vectors++;
         if (nb !== 32) begin miscompares++; $display("FAIL div%0d_busy_cycles: got %0d expected 32", k, nb); end
         vectors++;
         if (lat !== 33) begin miscompares++; $display("FAIL div%0d_latency: got %0d expected 33", k, lat); end
         vectors++;
         if (r !== ex[k]) begin miscompares++; $display("FAIL div%0d_result: got %h expected %h", k, r, ex[k]); end
      end
      tick();
   endtask

   task automatic test_corner();
      logic [4:0]  ops [4] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM};
      logic [31:0] as  [4] = '{32'h5, 32'h5, 32'h80000000, 32'h80000000};
      logic [31:0] bs  [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] ex  [4] = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00000000};
      int nb, lat; logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         issue(ops[k], as[k], bs[k], nb, lat, r);
         vectors++;
         if (nb !== 0) begin miscompares++; $display("FAIL corner%0d_busy: got %0d expected 0", k, nb); end
         vectors++;
         if (lat !== 1) begin miscompares++; $display("FAIL corner%0d_latency: got %0d expected 1", k, lat); end
         vectors++;
         if (r !== ex[k]) begin miscompares++; $display("FAIL corner%0d_result: got %h expected %h", k, r, ex[k]); end
      end
      tick();
      vectors++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin
         miscompares++; $display("FAIL corner_idle: got busy=%b done=%b expected 0 0", BUSY, DONE);
      end
   endtask

   task automatic test_flush();
      int nb, lat, pulses; logic [31:0] r;
      issue(OP_REMU, 32'h5, 32'h0, nb, lat, r);
      vectors++;
      if (r !== 32'h5) begin miscompares++; $display("FAIL flush_pre_result: got %h expected 00000005", r); end
      tick();
      OPCODE = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      vectors++;
      if (BUSY !== 1'b1) begin miscompares++; $display("FAIL flush_busy_c10: got %b expected 1", BUSY); end
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL flush_busy_c11: got %b expected 0", BUSY); end
      vectors++;
      if (RESULT !== 32'h5) begin miscompares++; $display("FAIL flush_result_kept: got %h expected 00000005", RESULT); end
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (DONE || BUSY) pulses++;
         tick();
      end
      vectors++;
      if (pulses !== 0) begin miscompares++; $display("FAIL flush_no_done: got %0d active cycles expected 0", pulses); end
      issue(OP_DIVU, 32'd100, 32'd7, nb, lat, r);
      vectors++;
      if (lat !== 33 || r !== 32'd14) begin
         miscompares++; $display("FAIL flush_restart: got lat=%0d res=%h expected lat=33 res=0000000e", lat, r);
      end
      tick();
      OPCODE = OP_MUL; DATA1 = 32'd3; DATA2 = 32'd3; START = 1'b1; FLUSH = 1'b1;
      tick();
      START = 1'b0; FLUSH = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         if (DONE || BUSY) pulses++;
         tick();
      end
      vectors++;
      if (pulses !== 0) begin miscompares++; $display("FAIL flush_idle_start: got %0d active cycles expected 0", pulses); end
   endtask

   task automatic test_reset_mid_op();
      OPCODE = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 1; i < 20; i++) tick();
      vectors++;
      if (BUSY !== 1'b1 || RESULT !== 32'd14) begin
         miscompares++; $display("FAIL rst_pre: got busy=%b res=%h expected busy=1 res=0000000e", BUSY, RESULT);
      end
      #2 RESET = 1'b0;
      #1;
      vectors++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_async: got busy=%b done=%b res=%h expected 0 0 00000000", BUSY, DONE, RESULT);
      end
      @(negedge CLK);
      RESET = 1'b1;
      tick();
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_after: got busy=%b expected 0", BUSY); end
   endtask

   task automatic test_ignored();
      int act, pulses, lat, nb; logic [31:0] r;
      OPCODE = 5'b00000; DATA1 = 32'd1; DATA2 = 32'd2; START = 1'b1;
      tick();
      START = 1'b0;
      act = 0;
      for (int i = 0; i < 3; i++) begin
         if (DONE || BUSY) act++;
         tick();
      end
      vectors++;
      if (act !== 0) begin miscompares++; $display("FAIL ignore_add: got %0d active cycles expected 0", act); end
      OPCODE = OP_MUL; DATA1 = 32'd3; DATA2 = 32'd5; START = 1'b1;
      tick();
      DATA1 = 32'd9;
      pulses = 0; lat = -1; nb = 0; r = 'x;
      for (int i = 1; i <= 45; i++) begin
         if (i == 21) START = 1'b0;
         if (BUSY) nb++;
         if (DONE) begin pulses++; lat = i; r = RESULT; end
         tick();
      end
      START = 1'b0;
      vectors++;
      if (pulses !== 1) begin miscompares++; $display("FAIL held_start_pulses: got %0d expected 1", pulses); end
      vectors++;
      if (lat !== 33 || nb !== 32) begin
         miscompares++; $display("FAIL held_start_timing: got lat=%0d busy=%0d expected 33 32", lat, nb);
      end
      vectors++;
      if (r !== 32'd15) begin miscompares++; $display("FAIL held_start_result: got %h expected 0000000f", r); end
   endtask

   initial begin
      RESET = 1'b0; START = 1'b0; FLUSH = 1'b0;
      OPCODE = 5'b0; DATA1 = 32'h0; DATA2 = 32'h0;
      test_reset();
      test_mul();
      test_mulh_back_to_back();
      test_div();
      test_corner();
      test_flush();
      test_reset_mid_op();
      test_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
